// File: rtl/hop_chain_if.sv
// hop_chain_if
//   Bundles the data-path and probe signals of hop_chain_pipe.
//   The master side (bench or surrounding fabric) drives advance, start,
//   start_vld, probe_go and, when HOP_STAGE_CLR_EN is defined, stage_clr.
//   The slave side (hop_chain_pipe) drives ff_out, out_vld, occ and the
//   probe_* status signals.
//   Per-channel fields are packed flat: channel c occupies [c*W +: W].
// Configuration macro: HOP_STAGE_CLR_EN (adds the stage_clr vector).
interface hop_chain_if #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 1,
  parameter int CNT_W  = 8
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                      advance;
  logic [NUM_CH*WIDTH-1:0]   start;
  logic [NUM_CH-1:0]         start_vld;
`ifdef HOP_STAGE_CLR_EN
  logic [NUM_CH*DEPTH-1:0]   stage_clr;
`endif
  logic [NUM_CH*WIDTH-1:0]   ff_out;
  logic [NUM_CH-1:0]         out_vld;
  logic [NUM_CH*OCC_W-1:0]   occ;
  logic [NUM_CH-1:0]         probe_go;
  logic [NUM_CH-1:0]         probe_busy;
  logic [NUM_CH-1:0]         probe_done;
  logic [NUM_CH*CNT_W-1:0]   probe_lat;
  logic [NUM_CH-1:0]         probe_ovf;

  modport master (
    output advance, start, start_vld,
`ifdef HOP_STAGE_CLR_EN
    output stage_clr,
`endif
    output probe_go,
    input  ff_out, out_vld, occ, probe_busy, probe_done, probe_lat, probe_ovf
  );

  modport slave (
    input  advance, start, start_vld,
`ifdef HOP_STAGE_CLR_EN
    input  stage_clr,
`endif
    input  probe_go,
    output ff_out, out_vld, occ, probe_busy, probe_done, probe_lat, probe_ovf
  );
endinterface

// File: rtl/hop_chain_pipe.sv
// hop_chain_pipe
//   NUM_CH independent DEPTH-stage register chains of WIDTH-bit data, each
//   stage carrying a valid bit and a probe tag bit. A shared advance shifts
//   every chain by one stage; advance=0 holds everything. Each channel owns a
//   latency probe (IDLE/ARM/MEAS/DONE) that tags one injected token and counts
//   cycles until the tag reaches the last stage, saturating at 2^CNT_W-1.
// Ports
//   clock0 : clock, all state on posedge
//   rst    : synchronous active-high reset
//   bus    : hop_chain_if.slave (advance, start, start_vld, probe_go,
//            [stage_clr], ff_out, out_vld, occ, probe_busy, probe_done,
//            probe_lat, probe_ovf)
// Configuration macro: HOP_STAGE_CLR_EN
//   defined   : stage_clr zeroes data/valid/tag of the selected stages on the
//               edge, overriding the shift into them.
//   undefined : stages are cleared only by rst.
module hop_chain_pipe #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 1,
  parameter int CNT_W  = 8
) (
  input  logic        clock0,
  input  logic        rst,
  hop_chain_if.slave  bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} probe_state_t;

  // Chain state
  logic [NUM_CH-1:0][DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [NUM_CH-1:0][DEPTH-1:0]            vld_q, vld_d;
  logic [NUM_CH-1:0][DEPTH-1:0]            tag_q, tag_d;
  logic [NUM_CH-1:0][DEPTH-1:0]            clr;
  logic [NUM_CH-1:0][OCC_W-1:0]            occ_q, occ_d;

  // Probe state
  probe_state_t     state_q [NUM_CH];
  probe_state_t     state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [CNT_W-1:0] lat_q   [NUM_CH];
  logic [CNT_W-1:0] lat_d   [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;

  // Per-channel probe events for this cycle
  logic [NUM_CH-1:0] inject;
  logic [NUM_CH-1:0] exit_hit;
  logic [NUM_CH-1:0] timeout;

`ifdef HOP_STAGE_CLR_EN
  assign clr = bus.stage_clr;
`else
  assign clr = '0;
`endif

  // Exit is checked before timeout so a token that arrives on the saturating
  // count is still reported as a real latency.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    inject   = '0;
    exit_hit = '0;
    timeout  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      inject[c]   = (state_q[c] == ARM) && bus.advance && bus.start_vld[c];
      exit_hit[c] = (state_q[c] == MEAS) && tag_q[c][DEPTH-1];
      timeout[c]  = (state_q[c] == MEAS) && !tag_q[c][DEPTH-1] && (cnt_q[c] == CNT_MAX);
    end
  end

  // Chain next state: shift, tag housekeeping, stage clears, occupancy.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    tag_d  = tag_q;
    occ_d  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.advance) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          data_d[c][k] = data_q[c][k-1];
          vld_d[c][k]  = vld_q[c][k-1];
          tag_d[c][k]  = tag_q[c][k-1];
        end
        data_d[c][0] = bus.start[c*WIDTH +: WIDTH];
        vld_d[c][0]  = bus.start_vld[c];
        tag_d[c][0]  = inject[c];
      end
      // A detected tag is retired even if the chain is stalled, so it cannot
      // be seen again by the next measurement on this channel.
      if (exit_hit[c]) tag_d[c][DEPTH-1] = 1'b0;
      if (timeout[c])  tag_d[c] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        if (clr[c][k]) begin
          data_d[c][k] = '0;
          vld_d[c][k]  = 1'b0;
          tag_d[c][k]  = 1'b0;
        end
      end
      // occ is registered from the next-state valids, so it matches the
      // stage contents right after the edge.
      for (int k = 0; k < DEPTH; k++) begin
        occ_d[c] = occ_d[c] + OCC_W'(vld_d[c][k]);
      end
    end
  end

  // Probe FSM next state and capture registers.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      lat_d[c]   = lat_q[c];
      ovf_d[c]   = ovf_q[c];
      case (state_q[c])
        IDLE: if (bus.probe_go[c]) state_d[c] = ARM;
        ARM: begin
          if (inject[c]) begin
            cnt_d[c]   = CNT_W'(1);
            state_d[c] = MEAS;
          end
        end
        MEAS: begin
          if (exit_hit[c]) begin
            lat_d[c]   = cnt_q[c];
            ovf_d[c]   = 1'b0;
            state_d[c] = DONE;
          end else if (timeout[c]) begin
            lat_d[c]   = CNT_MAX;
            ovf_d[c]   = 1'b1;
            state_d[c] = DONE;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
        DONE:    state_d[c] = IDLE;
        default: state_d[c] = IDLE;
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock0) begin
    if (rst) begin
      // NOTE: the chain is a bank of flops, not a RAM, so it takes a reset; valid and tag must read 0 immediately after rst.
      data_q <= '0;
      vld_q  <= '0;
      tag_q  <= '0;
      occ_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      tag_q  <= tag_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clock0) begin
    if (rst) begin
      ovf_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
        lat_q[c]   <= '0;
      end
    end else begin
      ovf_q <= ovf_d;
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        lat_q[c]   <= lat_d[c];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign bus.ff_out[c*WIDTH +: WIDTH]    = data_q[c][DEPTH-1];
    assign bus.out_vld[c]                  = vld_q[c][DEPTH-1];
    assign bus.occ[c*OCC_W +: OCC_W]       = occ_q[c];
    assign bus.probe_busy[c]               = (state_q[c] != IDLE);
    assign bus.probe_done[c]               = (state_q[c] == DONE);
    assign bus.probe_lat[c*CNT_W +: CNT_W] = lat_q[c];
    assign bus.probe_ovf[c]                = ovf_q[c];
  end

endmodule

// File: tb/tb_hop_chain_pipe.sv
// tb_hop_chain_pipe
//   Self-checking bench for hop_chain_pipe. The reference model keeps a log of
//   every value pushed into each chain, indexed by advance count; the last
//   stage is simply the entry DEPTH advances old. Probe latency is derived from
//   the edge numbers at which the token entered and reached the end.
module tb_hop_chain_pipe;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 8;
  localparam int WIDTH  = 1;
  localparam int CNT_W  = 8;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int LOG_N  = 4096;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic clock0 = 1'b0;
  logic rst;
  always #5 clock0 = ~clock0;

  hop_chain_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  hop_chain_pipe #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock0 (clock0),
    .rst    (rst),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] dlog [NUM_CH][LOG_N];
  bit               vlog [NUM_CH][LOG_N];
  int nadv   = 0;   // advancing edges since reset
  int edge_n = 0;   // all edges

  bit               m_busy  [NUM_CH];
  bit               m_armed [NUM_CH];
  bit               m_fly   [NUM_CH];
  bit               m_lost  [NUM_CH];
  bit               m_dpend [NUM_CH];
  bit               m_done  [NUM_CH];
  bit               m_ovf   [NUM_CH];
  int               m_inj   [NUM_CH];
  int               m_tok   [NUM_CH];
  int               m_exit  [NUM_CH];
  logic [CNT_W-1:0] m_lat   [NUM_CH];

  task automatic model_edge();
    edge_n++;
    if (rst) begin
      nadv = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_busy[c] = 0; m_armed[c] = 0; m_fly[c] = 0; m_lost[c] = 0;
        m_dpend[c] = 0; m_done[c] = 0; m_ovf[c] = 0; m_lat[c] = '0; m_exit[c] = -1;
      end
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      m_done[c] = 0;
      if (m_dpend[c]) begin
        m_dpend[c] = 0;
        m_busy[c]  = 0;
      end else if (m_fly[c]) begin
        if (m_exit[c] >= 0) begin
          m_lat[c] = CNT_W'(m_exit[c] - m_inj[c] + 1);
          m_ovf[c] = 0;
          m_fly[c] = 0; m_done[c] = 1; m_dpend[c] = 1;
        end else if (edge_n - m_inj[c] == SAT) begin
          m_lat[c] = '1;
          m_ovf[c] = 1;
          m_fly[c] = 0; m_done[c] = 1; m_dpend[c] = 1;
        end
      end else if (m_armed[c] && bus.advance && bus.start_vld[c]) begin
        m_armed[c] = 0;
        m_fly[c]   = 1;
        m_lost[c]  = 0;
        m_inj[c]   = edge_n;
        m_tok[c]   = nadv;
        m_exit[c]  = -1;
      end else if (!m_busy[c] && bus.probe_go[c]) begin
        m_busy[c]  = 1;
        m_armed[c] = 1;
      end
    end
    if (bus.advance) begin
      for (int c = 0; c < NUM_CH; c++) begin
        dlog[c][nadv] = bus.start[c*WIDTH +: WIDTH];
        vlog[c][nadv] = bus.start_vld[c];
      end
      nadv++;
    end
`ifdef HOP_STAGE_CLR_EN
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (bus.stage_clr[c*DEPTH + k] && (nadv - 1 - k) >= 0) begin
          dlog[c][nadv-1-k] = '0;
          vlog[c][nadv-1-k] = 0;
          if (m_fly[c] && (nadv - 1 - k) == m_tok[c]) m_lost[c] = 1;
        end
      end
    end
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_fly[c] && !m_lost[c] && m_exit[c] < 0 && nadv == m_tok[c] + DEPTH)
        m_exit[c] = edge_n;
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NUM_CH; c++) begin
      logic [WIDTH-1:0] e_d;
      logic             e_v;
      int               e_occ;
      e_d   = '0;
      e_v   = 1'b0;
      e_occ = 0;
      if (nadv >= DEPTH) begin
        e_d = dlog[c][nadv-DEPTH];
        e_v = vlog[c][nadv-DEPTH];
      end
      for (int j = (nadv > DEPTH ? nadv - DEPTH : 0); j < nadv; j++) e_occ += int'(vlog[c][j]);
      check($sformatf("ff_out%0d", c),  bus.ff_out[c*WIDTH +: WIDTH], e_d);
      check($sformatf("out_vld%0d", c), bus.out_vld[c], e_v);
      check($sformatf("occ%0d", c),     bus.occ[c*OCC_W +: OCC_W], e_occ);
      check($sformatf("busy%0d", c),    bus.probe_busy[c], m_busy[c]);
      check($sformatf("done%0d", c),    bus.probe_done[c], m_done[c]);
      check($sformatf("lat%0d", c),     bus.probe_lat[c*CNT_W +: CNT_W], m_lat[c]);
      check($sformatf("ovf%0d", c),     bus.probe_ovf[c], m_ovf[c]);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock0);
    #1;
    compare_all();
  endtask

  task automatic wait_done(input int c, input int max_cyc);
    int n;
    n = 0;
    while (bus.probe_done[c] !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    check($sformatf("done_seen%0d", c), bus.probe_done[c], 1'b1);
  endtask

  task automatic idle_inputs();
    bus.advance   = 1'b0;
    bus.start     = '0;
    bus.start_vld = '0;
    bus.probe_go  = '0;
`ifdef HOP_STAGE_CLR_EN
    bus.stage_clr = '0;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    check("rst_busy", bus.probe_busy, '0);
    check("rst_occ",  bus.occ, '0);
    rst = 1'b0;

    // Single token through channel 0: appears after DEPTH advancing edges.
    bus.advance = 1'b1;
    bus.start_vld[0] = 1'b1;
    bus.start[0] = 1'b1;
    tick();
    bus.start_vld[0] = 1'b0;
    bus.start[0] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t1_not_yet", bus.out_vld[0], 1'b0);
    tick();
    check("t1_out_vld", bus.out_vld[0], 1'b1);
    check("t1_ff_out",  bus.ff_out[0], 1'b1);
    tick();
    check("t1_one_cyc", bus.out_vld[0], 1'b0);

    // Occupancy holds while stalled.
    rst = 1'b1; tick(); rst = 1'b0;
    bus.start_vld[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.start_vld[0] = 1'b0;
    bus.advance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_occ_hold", bus.occ[OCC_W-1:0], 5);
    end
    bus.advance = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t2_out_rise", bus.out_vld[0], 1'b1);

    // Probe with continuous advance.
    bus.probe_go[1] = 1'b1; tick(); bus.probe_go[1] = 1'b0;
    bus.start_vld[1] = 1'b1;
    wait_done(1, 40);
    check("t3_lat", bus.probe_lat[2*CNT_W-1:CNT_W], DEPTH);
    check("t3_ovf", bus.probe_ovf[1], 1'b0);

    // Probe with a 4-cycle stall mid-flight.
    bus.start_vld[1] = 1'b0;
    tick(); tick();
    bus.probe_go[1] = 1'b1; tick(); bus.probe_go[1] = 1'b0;
    bus.start_vld[1] = 1'b1; tick(); bus.start_vld[1] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.advance = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bus.advance = 1'b1;
    wait_done(1, 40);
    check("t4_lat", bus.probe_lat[2*CNT_W-1:CNT_W], DEPTH + 4);

    // Timeout: token injected, chain stalled until the counter saturates.
    tick();
    bus.probe_go[0] = 1'b1; tick(); bus.probe_go[0] = 1'b0;
    bus.start_vld[0] = 1'b1; tick(); bus.start_vld[0] = 1'b0;
    bus.advance = 1'b0;
    wait_done(0, 300);
    check("t5_lat", bus.probe_lat[CNT_W-1:0], SAT);
    check("t5_ovf", bus.probe_ovf[0], 1'b1);
    bus.advance = 1'b1;
    for (int i = 0; i < 12; i++) tick();

`ifdef HOP_STAGE_CLR_EN
    // Clear the stage holding the tagged token: measurement must time out.
    bus.probe_go[1] = 1'b1; tick(); bus.probe_go[1] = 1'b0;
    bus.start_vld[1] = 1'b1; tick(); bus.start_vld[1] = 1'b0;
    bus.stage_clr[DEPTH + 1] = 1'b1; tick(); bus.stage_clr = '0;
    wait_done(1, 300);
    check("t6_lat", bus.probe_lat[2*CNT_W-1:CNT_W], SAT);
    check("t6_ovf", bus.probe_ovf[1], 1'b1);
    tick();
`endif

    // Reset during MEAS aborts the measurement with no done pulse.
    bus.probe_go[1] = 1'b1; tick(); bus.probe_go[1] = 1'b0;
    bus.start_vld[1] = 1'b1; tick(); bus.start_vld[1] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1; tick();
    check("t7_busy", bus.probe_busy[1], 1'b0);
    check("t7_done", bus.probe_done[1], 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t7_no_done", bus.probe_done[1], 1'b0);
    end

    // Randomised traffic, stalls and probe requests.
    for (int i = 0; i < 900; i++) begin
      bus.advance   = ($urandom_range(0, 4) != 0);
      bus.start     = NUM_CH*WIDTH'($urandom);
      bus.start_vld = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++) bus.probe_go[c] = ($urandom_range(0, 15) == 0);
`ifdef HOP_STAGE_CLR_EN
      for (int b = 0; b < NUM_CH*DEPTH; b++) bus.stage_clr[b] = ($urandom_range(0, 63) == 0);
`endif
      tick();
    end
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
